// File: rtl/alu_pkg.sv
// Shared encodings, FSM state type and sizing helper for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpSub  = 4'b0100;
  localparam logic [3:0] OpMulu = 4'b0101;
  localparam logic [3:0] OpSlt  = 4'b0110;
  localparam logic [3:0] OpSltu = 4'b0111;
  localparam logic [3:0] OpNor  = 4'b1000;
  localparam logic [3:0] OpDivu = 4'b1001;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv
  } alu_state_e;

  // Bits needed to count iterations 0..w-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/result bundle between the EX stage and the multi-cycle ALU.
interface alu_multicycle_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [3:0]       ALU_Control;
  logic [WIDTH-1:0] Src1;
  logic [WIDTH-1:0] Src2;
  logic [WIDTH-1:0] ALU_Result;
  logic [WIDTH-1:0] ALU_Result_Hi;
  logic             Zero_Flag;
  logic             Overflow_Flag;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, ALU_Control, Src1, Src2,
    input  ALU_Result, ALU_Result_Hi, Zero_Flag, Overflow_Flag, Busy, Done
  );

  modport slave (
    input  Start, ALU_Control, Src1, Src2,
    output ALU_Result, ALU_Result_Hi, Zero_Flag, Overflow_Flag, Busy, Done
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned core: shift-add multiply or restoring divide, one bit per cycle.
// o_lo/o_hi present the value after the current iteration so the owner can
// capture results on the same edge that completes the last iteration.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_go,
  input  logic             i_op,    // 1 = divide, 0 = multiply
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic             o_last
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic            r_run;
  logic            r_div;
  logic [CntW-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;    // multiplicand / divisor
  logic [WIDTH-1:0] r_b;    // multiplier shifting out / dividend shifting into quotient
  logic [WIDTH-1:0] r_acc;  // product high word / partial remainder

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;

  assign w_addend = r_b[0] ? r_a : '0;
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_addend};
  assign w_shift  = {r_acc, r_b[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_a};
  // No borrow means the shifted remainder is at least the divisor.
  assign w_fits   = ~w_diff[WIDTH];

  assign o_hi   = r_div ? (w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]) : w_sum[WIDTH:1];
  assign o_lo   = r_div ? {r_b[WIDTH-2:0], w_fits} : {w_sum[0], r_b[WIDTH-1:1]};
  assign o_last = r_run && (r_cnt == LastCnt);

  // Operand latch on go, then one iteration per cycle until the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run <= 1'b0;
      r_div <= 1'b0;
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (i_go) begin
      r_run <= 1'b1;
      r_div <= i_op;
      r_cnt <= '0;
      r_a   <= i_b;
      r_b   <= i_a;
      r_acc <= '0;
    end else if (r_run) begin
      r_acc <= o_hi;
      r_b   <= o_lo;
      if (o_last) begin
        r_run <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU top: FSM, single-cycle ops, flags and start/done handshake.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  alu_multicycle_if.slave   bus
);

  alu_state_e r_state, w_state;

  logic [WIDTH-1:0] r_result, r_result_hi;
  logic             r_zero, r_ovf, r_done;

  logic [WIDTH-1:0] w_sum, w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ovf;
  logic [WIDTH-1:0] w_core_lo, w_core_hi;
  logic             w_core_last;

  logic             w_go, w_load, w_ovf;
  logic [WIDTH-1:0] w_res, w_hi;

  assign w_sum  = bus.Src1 + bus.Src2;
  assign w_diff = bus.Src1 - bus.Src2;

  // Single-cycle result and signed overflow; unknown codes yield all zeros.
  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (bus.ALU_Control)
      OpAnd:  w_alu_res = bus.Src1 & bus.Src2;
      OpOr:   w_alu_res = bus.Src1 | bus.Src2;
      OpXor:  w_alu_res = bus.Src1 ^ bus.Src2;
      OpNor:  w_alu_res = ~(bus.Src1 | bus.Src2);
      OpAdd: begin
        w_alu_res = w_sum;
        w_alu_ovf = (bus.Src1[WIDTH-1] == bus.Src2[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != bus.Src1[WIDTH-1]);
      end
      OpSub: begin
        w_alu_res = w_diff;
        w_alu_ovf = (bus.Src1[WIDTH-1] != bus.Src2[WIDTH-1]) &&
                    (w_diff[WIDTH-1] != bus.Src1[WIDTH-1]);
      end
      OpSlt:  w_alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.Src1) < $signed(bus.Src2)};
      OpSltu: w_alu_res = {{(WIDTH-1){1'b0}}, bus.Src1 < bus.Src2};
      default: ;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .i_go   (w_go),
    .i_op   (bus.ALU_Control == OpDivu),
    .i_a    (bus.Src1),
    .i_b    (bus.Src2),
    .o_lo   (w_core_lo),
    .o_hi   (w_core_hi),
    .o_last (w_core_last)
  );

  // Next state, core launch and result-load selection.
  always_comb begin
    w_state = r_state;
    w_go    = 1'b0;
    w_load  = 1'b0;
    w_res   = '0;
    w_hi    = '0;
    w_ovf   = 1'b0;
    case (r_state)
      StIdle: begin
        if (bus.Start) begin
          if (bus.ALU_Control == OpMulu) begin
            w_go    = 1'b1;
            w_state = StMul;
          end else if (bus.ALU_Control == OpDivu) begin
            w_go    = 1'b1;
            w_state = StDiv;
          end else begin
            w_load = 1'b1;
            w_res  = w_alu_res;
            w_ovf  = w_alu_ovf;
          end
        end
      end
      StMul, StDiv: begin
        if (w_core_last) begin
          w_load  = 1'b1;
          w_res   = w_core_lo;
          w_hi    = w_core_hi;
          w_state = StIdle;
        end
      end
      default: w_state = StIdle;
    endcase
  end

  // State and output registers; outputs hold until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b1;
      r_ovf       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state;
      r_done  <= w_load;
      if (w_load) begin
        r_result    <= w_res;
        r_result_hi <= w_hi;
        r_zero      <= (w_res == '0);
        r_ovf       <= w_ovf;
      end
    end
  end

  assign bus.ALU_Result    = r_result;
  assign bus.ALU_Result_Hi = r_result_hi;
  assign bus.Zero_Flag     = r_zero;
  assign bus.Overflow_Flag = r_ovf;
  assign bus.Done          = r_done;
  assign bus.Busy          = (r_state != StIdle);

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=32 and WIDTH=8.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst8;
  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(32)) bus32 ();
  alu_multicycle_if #(.WIDTH(8))  bus8 ();

  alu_multicycle #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst),  .bus(bus32));
  alu_multicycle #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst8), .bus(bus8));

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input string name, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res, input logic ovf);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.res = res;
    v.zero = (res == 32'h0); v.ovf = ovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset32(input string tag);
    check({tag, ".res"},  {32'h0, bus32.ALU_Result}, 64'h0);
    check({tag, ".hi"},   {32'h0, bus32.ALU_Result_Hi}, 64'h0);
    check({tag, ".zero"}, {63'h0, bus32.Zero_Flag}, 64'h1);
    check({tag, ".ovf"},  {63'h0, bus32.Overflow_Flag}, 64'h0);
    check({tag, ".busy"}, {63'h0, bus32.Busy}, 64'h0);
    check({tag, ".done"}, {63'h0, bus32.Done}, 64'h0);
  endtask

  // Issue a 32-bit MULU/DIVU, poke a stray Start while busy, check timing and results.
  task automatic run_multi(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi);
    logic busy_ok;
    bus32.Start = 1'b1; bus32.ALU_Control = op; bus32.Src1 = a; bus32.Src2 = b;
    tick();  // cycle 1
    bus32.Start = 1'b0;
    check({name, ".busy1"}, {62'h0, bus32.Busy, bus32.Done}, 64'h2);
    busy_ok = 1'b1;
    for (int c = 2; c <= 32; c++) begin
      if (c == 4) begin
        bus32.Start = 1'b1; bus32.ALU_Control = OpAdd;
        bus32.Src1 = 32'h1111_1111; bus32.Src2 = 32'h2222_2222;
      end
      if (c == 12) bus32.Start = 1'b0;
      tick();
      if (!(bus32.Busy === 1'b1 && bus32.Done === 1'b0)) busy_ok = 1'b0;
    end
    check({name, ".busy2to32"}, {63'h0, busy_ok}, 64'h1);
    tick();  // cycle 33
    check({name, ".done33"}, {62'h0, bus32.Busy, bus32.Done}, 64'h1);
    check({name, ".hilo"}, {bus32.ALU_Result_Hi, bus32.ALU_Result}, {exp_hi, exp_lo});
    check({name, ".zero"}, {63'h0, bus32.Zero_Flag}, {63'h0, exp_lo == 32'h0});
    check({name, ".ovf"},  {63'h0, bus32.Overflow_Flag}, 64'h0);
    tick();  // results hold, Done drops
    check({name, ".hold"}, {bus32.ALU_Result_Hi, bus32.ALU_Result}, {exp_hi, exp_lo});
    check({name, ".donedrop"}, {62'h0, bus32.Busy, bus32.Done}, 64'h0);
  endtask

  initial begin
    logic no_done;
    logic busy_ok;

    vecs[0]  = mk("add_ovf",   OpAdd,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
    vecs[1]  = mk("sub_zero",  OpSub,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0);
    vecs[2]  = mk("slt",       OpSlt,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0);
    vecs[3]  = mk("sltu",      OpSltu, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
    vecs[4]  = mk("and",       OpAnd,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0);
    vecs[5]  = mk("or",        OpOr,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0);
    vecs[6]  = mk("xor",       OpXor,  32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0);
    vecs[7]  = mk("nor",       OpNor,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
    vecs[8]  = mk("sub_ovf",   OpSub,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
    vecs[9]  = mk("add_wrap",  OpAdd,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
    vecs[10] = mk("bad_code",  4'hF,   32'h0000_1234, 32'h0000_5678, 32'h0000_0000, 1'b0);
    vecs[11] = mk("sub_neg",   OpSub,  32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0);
    vecs[12] = mk("add_ovf0",  OpAdd,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);

    rst = 1'b1; rst8 = 1'b1;
    bus32.Start = 1'b0; bus32.ALU_Control = 4'h0; bus32.Src1 = '0; bus32.Src2 = '0;
    bus8.Start  = 1'b0; bus8.ALU_Control  = 4'h0; bus8.Src1  = '0; bus8.Src2  = '0;
    repeat (3) tick();
    check_reset32("reset");
    rst = 1'b0; rst8 = 1'b0;
    tick();

    // Back-to-back single-cycle ops: each Start lands in the previous Done cycle.
    for (int i = 0; i < 13; i++) begin
      bus32.Start = 1'b1; bus32.ALU_Control = vecs[i].op;
      bus32.Src1 = vecs[i].a; bus32.Src2 = vecs[i].b;
      tick();
      check({vecs[i].name, ".res"},  {32'h0, bus32.ALU_Result}, {32'h0, vecs[i].res});
      check({vecs[i].name, ".hi"},   {32'h0, bus32.ALU_Result_Hi}, 64'h0);
      check({vecs[i].name, ".flags"}, {62'h0, bus32.Zero_Flag, bus32.Overflow_Flag},
            {62'h0, vecs[i].zero, vecs[i].ovf});
      check({vecs[i].name, ".hs"},   {62'h0, bus32.Busy, bus32.Done}, 64'h1);
    end
    bus32.Start = 1'b0;
    tick();
    check("idle.done", {63'h0, bus32.Done}, 64'h0);

    run_multi("mulu_max", OpMulu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
    run_multi("divu",     OpDivu, 32'd100, 32'd7, 32'd14, 32'd2);
    run_multi("divu_z",   OpDivu, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9);

    // Single op after a divide clears the high word.
    bus32.Start = 1'b1; bus32.ALU_Control = OpAdd; bus32.Src1 = 32'd1; bus32.Src2 = 32'd1;
    tick();
    bus32.Start = 1'b0;
    check("add_after_div.res", {32'h0, bus32.ALU_Result}, 64'd2);
    check("add_after_div.hi",  {32'h0, bus32.ALU_Result_Hi}, 64'h0);

    // Reset in cycle 10 of a MULU aborts it without a Done.
    bus32.Start = 1'b1; bus32.ALU_Control = OpMulu; bus32.Src1 = 32'd3; bus32.Src2 = 32'd5;
    tick();  // cycle 1
    bus32.Start = 1'b0;
    repeat (9) tick();  // cycle 10
    check("abort.busy10", {63'h0, bus32.Busy}, 64'h1);
    rst = 1'b1;
    tick();
    check_reset32("abort");
    rst = 1'b0;
    no_done = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus32.Done !== 1'b0 || bus32.Busy !== 1'b0) no_done = 1'b0;
    end
    check("abort.nodone", {63'h0, no_done}, 64'h1);
    bus32.Start = 1'b1; bus32.ALU_Control = OpAdd; bus32.Src1 = 32'd2; bus32.Src2 = 32'd3;
    tick();
    bus32.Start = 1'b0;
    check("post_abort.add", {31'h0, bus32.Done, bus32.ALU_Result}, {31'h0, 1'b1, 32'd5});

    // Reset and Start on the same edge: Start is dropped.
    rst = 1'b1;
    bus32.Start = 1'b1; bus32.ALU_Control = OpAdd; bus32.Src1 = 32'd7; bus32.Src2 = 32'd8;
    tick();
    rst = 1'b0;
    bus32.Start = 1'b0;
    check_reset32("rst_start");
    tick();
    check("rst_start.after", {31'h0, bus32.Done, bus32.ALU_Result}, 64'h0);

    // WIDTH=8 multiply: Done in cycle 9.
    bus8.Start = 1'b1; bus8.ALU_Control = OpMulu; bus8.Src1 = 8'hFF; bus8.Src2 = 8'h02;
    tick();  // cycle 1
    bus8.Start = 1'b0;
    check("w8.busy1", {62'h0, bus8.Busy, bus8.Done}, 64'h2);
    busy_ok = 1'b1;
    for (int c = 2; c <= 8; c++) begin
      tick();
      if (!(bus8.Busy === 1'b1 && bus8.Done === 1'b0)) busy_ok = 1'b0;
    end
    check("w8.busy2to8", {63'h0, busy_ok}, 64'h1);
    tick();  // cycle 9
    check("w8.done9", {62'h0, bus8.Busy, bus8.Done}, 64'h1);
    check("w8.hilo", {48'h0, bus8.ALU_Result_Hi, bus8.ALU_Result}, 64'h01FE);
    check("w8.zero", {63'h0, bus8.Zero_Flag}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised multi-cycle ALU for the MIPS datapath, successor to the 32-bit single-cycle ALU. Simple operations complete in one registered cycle. Unsigned multiply and divide run iteratively over WIDTH cycles, with full high/low result, signed overflow and a start/done handshake. It sits in EX and stalls the pipeline through Busy while a multi-cycle operation is in flight.

## Interface

- WIDTH, 32: operand/result width; must be ≥ 4 and even.
- clk  in  1: single clock; all state updates on rising edge.
- rst  in  1: synchronous, active-high reset.
- Start  in  1: request; sampled on a rising edge only when Busy=0.
- ALU_Control  in  4: operation code (encodings below).
- Src1  in  WIDTH: operand A.
- Src2  in  WIDTH: operand B.
- ALU_Result  out  WIDTH: result low word / quotient.
- ALU_Result_Hi  out  WIDTH: product high word / remainder; 0 for other ops.
- Zero_Flag  out  1: ALU_Result == 0.
- Overflow_Flag  out  1: signed overflow of ADD/SUB; 0 for other ops.
- Busy  out  1: multi-cycle operation in progress.
- Done  out  1: one-cycle pulse; results valid and updated this cycle.

## Operation

- Encodings: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SUB, 0101 MULU, 0110 SLT (signed), 0111 SLTU, 1000 NOR, 1001 DIVU.
  - All other codes complete in one cycle with every result and flag set to 0.
- ADD/SUB wrap modulo 2^WIDTH.
  - Overflow_Flag: operands of the same sign (ADD) or of differing sign (SUB) and the result sign differs from Src1.
- SLT/SLTU: result is 1 or 0, zero-extended. Every code writes ALU_Result, so there is no stale hold as in the old ALU.
- MULU: shift-add, one partial-product bit per cycle. Full 2·WIDTH product is split as {ALU_Result_Hi, ALU_Result}.
- DIVU: restoring, one quotient bit per cycle. ALU_Result = quotient, ALU_Result_Hi = remainder.
  - Src2 = 0: quotient all ones, remainder = Src1. No exception.
- FSM states are IDLE, MUL and DIV.
  - IDLE + Start + MULU/DIVU: latch operands, clear counter, go to MUL or DIV.
  - IDLE + Start + any other code: compute and register results, pulse Done, stay IDLE.
  - MUL/DIV: one iteration per cycle. When the counter reaches WIDTH-1, write results, pulse Done and return to IDLE.
- Operands are latched at acceptance. Src changes while Busy have no effect.
- Start while Busy=1 is ignored. The request is not queued.
- Outputs and flags hold their last values until the next Done.
- Zero_Flag is registered from the final ALU_Result. It is valid with Done and held after.

## Timing

- Accept edge is E0, at the end of cycle 0 with Start=1 and Busy=0.
- Single-cycle ops: results and Done=1 in cycle 1. Busy stays 0.
- MULU/DIVU:
  - Busy=1 in cycles 1..WIDTH.
  - Iterations occur at edges E1..E_WIDTH.
  - Results and Done=1 in cycle WIDTH+1, with Busy=0 in that cycle.
- Back-to-back: Start in a Done cycle is accepted, so throughput is 1/cycle for simple ops and 1 per WIDTH+1 cycles for MUL/DIV.
- Reset values: ALU_Result=0, ALU_Result_Hi=0, Zero_Flag=1, Overflow_Flag=0, Busy=0, Done=0, state IDLE, counter 0.
- rst asserted mid-operation aborts in the next cycle with the reset values above. No Done is produced for the aborted operation.
- rst and Start on the same edge: rst wins and Start is dropped.

## Structure

- Package alu_pkg holds:
  - ALU_Control encoding localparams.
  - The FSM state enum (IDLE/MUL/DIV).
  - A clog2-based counter-width function.
- Sub-module alu_muldiv_iter: iterative shift-add/restoring core with its own operand, accumulator and counter registers.
  - Interface: go/op/a/b in; lo/hi/last out.
  - The top level owns the FSM, the single-cycle ops, the flags and the handshake.

## Test plan

- WIDTH=32, ADD 0x7FFFFFFF+1 → cycle 1: Result 0x80000000, Overflow_Flag=1, Zero_Flag=0, Done=1, Busy=0.
- SUB 5-5 then SLT 0xFFFFFFFF,1 back-to-back → Result 0, Zero=1; then Result 1. SLTU with the same operands gives 0.
- MULU 0xFFFFFFFF×0xFFFFFFFF → Busy cycles 1..32, Done cycle 33, Hi=0xFFFFFFFE, Lo=0x00000001. Start during Busy is ignored.
- DIVU 100/7 → Result 14, Hi 2 at cycle 33. DIVU 9/0 → Result 0xFFFFFFFF, Hi 9.
- rst at cycle 10 of a MULU → reset values next cycle, no Done pulse. A following ADD 2+3 gives 5.
- WIDTH=8: MULU 0xFF×0x02 → Done cycle 9, Hi=0x01, Lo=0xFE.
